// File: rtl/rgb_seq_pkg.sv
// rtl/rgb_seq_pkg.sv - shared colour type, colour table and FSM encoding for rgb_fade_sequencer
package rgb_seq_pkg;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb8_t;

   localparam int N_COLORS = 6;
   localparam int IDX_W    = $clog2(N_COLORS);

   // Leftmost element is index 0: red, yellow, green, cyan, blue, magenta.
   localparam rgb8_t [0:N_COLORS-1] COLOR_TABLE = {
      24'hFF0000, 24'hFFFF00, 24'h00FF00, 24'h00FFFF, 24'h0000FF, 24'hFF00FF
   };

   typedef enum logic [1:0] {
      IDLE,
      FADE,
      HOLD
   } seq_state_t;

   function automatic rgb8_t table_entry(input logic [IDX_W-1:0] idx);
      if (int'(idx) < N_COLORS) return COLOR_TABLE[idx];
      return COLOR_TABLE[0];
   endfunction

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - divides clk into one-cycle sequencer ticks, frozen while disabled
module tick_prescaler #(
   parameter int TICK_CYCLES = 12000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

   logic [CW-1:0] count;

   assign tick = en && (count == CW'(TICK_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en) begin
         count <= tick ? '0 : count + CW'(1);
      end
   end

endmodule

// File: rtl/rgb_fade_sequencer.sv
// rtl/rgb_fade_sequencer.sv - start/stop colour-table fader driving three PWM duty values
// Define RGB_SEQ_LOOP_EN to wrap back to the first entry instead of stopping with a done pulse.
module rgb_fade_sequencer
   import rgb_seq_pkg::*;
#(
   parameter  int PWM_INTERVAL = 1200,
   parameter  int TICK_CYCLES  = 12000,
   parameter  int FADE_TICKS   = 256,
   parameter  int HOLD_TICKS   = 500,
   localparam int DW           = $clog2(PWM_INTERVAL + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             stop,
   output logic [DW-1:0]    duty_r,
   output logic [DW-1:0]    duty_g,
   output logic [DW-1:0]    duty_b,
   output logic [IDX_W-1:0] step_idx,
   output logic             busy,
   output logic             done
);

   localparam int TW = $clog2(FADE_TICKS + 1);
   localparam int SH = $clog2(FADE_TICKS);
   localparam int HW = $clog2(HOLD_TICKS + 1);
   localparam int PW = 11 + TW;
   localparam int MW = 8 + DW;

   seq_state_t    state;
   rgb8_t         cur;
   rgb8_t         src_c;
   rgb8_t         dst_c;
   rgb8_t         nxt;
   rgb8_t         live;
   logic [TW-1:0] t;
   logic [HW-1:0] hold_cnt;
   logic          upd;
   logic          finished;
   logic          tick;
   logic          go;
   logic          last_entry;

   // Signed step with truncation toward zero; the shift alone would round toward -inf.
   function automatic logic [7:0] lerp(input logic [7:0] a, input logic [7:0] b,
                                       input logic [TW-1:0] tt);
      logic signed [9:0]    diff;
      logic signed [PW-1:0] prod;
      logic signed [PW-1:0] q;
      diff = $signed({2'b00, b}) - $signed({2'b00, a});
      prod = PW'(diff) * $signed(PW'(tt));
      if (prod < 0) q = -((-prod) >>> SH);
      else          q = prod >>> SH;
      return 8'($signed(PW'(a)) + q);
   endfunction

   function automatic logic [DW-1:0] to_duty(input logic [7:0] c);
      logic [MW-1:0] m;
      m = MW'(c) * MW'(PWM_INTERVAL);
      return DW'(m / MW'(255));
   endfunction

   assign go         = (state == IDLE) && start && !stop;
   assign dst_c      = table_entry(step_idx);
   assign nxt        = {lerp(src_c.r, dst_c.r, t), lerp(src_c.g, dst_c.g, t), lerp(src_c.b, dst_c.b, t)};
   assign live       = upd ? nxt : cur;
   assign last_entry = (step_idx == IDX_W'(N_COLORS - 1));
   assign busy       = (state != IDLE);

   tick_prescaler #(
      .TICK_CYCLES(TICK_CYCLES)
   ) u_prescaler (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (busy),
      .clr  (go),
      .tick (tick)
   );

`ifndef RGB_SEQ_LOOP_EN
   logic done_q;
   assign done = done_q;
`else
   assign done = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         step_idx <= '0;
         cur      <= '0;
         src_c    <= '0;
         t        <= '0;
         hold_cnt <= '0;
         upd      <= 1'b0;
         finished <= 1'b0;
         duty_r   <= '0;
         duty_g   <= '0;
         duty_b   <= '0;
`ifndef RGB_SEQ_LOOP_EN
         done_q   <= 1'b0;
`endif
      end else begin
         upd <= 1'b0;
`ifndef RGB_SEQ_LOOP_EN
         done_q <= 1'b0;
`endif
         // Colour lands one cycle after its tick; a concurrent stop freezes it instead.
         if (upd && !stop) begin
            cur    <= nxt;
            duty_r <= to_duty(nxt.r);
            duty_g <= to_duty(nxt.g);
            duty_b <= to_duty(nxt.b);
         end
         if (stop) begin
            state <= IDLE;
         end else begin
            case (state)
               IDLE: if (start) begin
                  state    <= FADE;
                  src_c    <= cur;
                  t        <= '0;
                  hold_cnt <= '0;
                  if (finished) begin
                     step_idx <= '0;
                     finished <= 1'b0;
                  end
               end
               FADE: if (tick) begin
                  t   <= t + TW'(1);
                  upd <= 1'b1;
                  if (t == TW'(FADE_TICKS - 1)) state <= HOLD;
               end
               HOLD: if (tick) begin
                  if (hold_cnt == HW'(HOLD_TICKS - 1)) begin
                     hold_cnt <= '0;
                     if (last_entry) begin
`ifdef RGB_SEQ_LOOP_EN
                        step_idx <= '0;
                        state    <= FADE;
                        src_c    <= live;
                        t        <= '0;
`else
                        state    <= IDLE;
                        done_q   <= 1'b1;
                        finished <= 1'b1;
`endif
                     end else begin
                        step_idx <= step_idx + IDX_W'(1);
                        state    <= FADE;
                        src_c    <= live;
                        t        <= '0;
                     end
                  end else begin
                     hold_cnt <= hold_cnt + HW'(1);
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
